// File: rtl/mc_pkg.sv
// mc_pkg: shared state codes, opcodes and ALU codes for the multicycle sequencer.
package mc_pkg;

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEM_ADDR = 4'd2;
  localparam logic [3:0] ST_MEM_RD   = 4'd3;
  localparam logic [3:0] ST_MEM_WB   = 4'd4;
  localparam logic [3:0] ST_MEM_WR   = 4'd5;
  localparam logic [3:0] ST_EXEC     = 4'd6;
  localparam logic [3:0] ST_ALU_WB   = 4'd7;
  localparam logic [3:0] ST_BRANCH   = 4'd8;
  localparam logic [3:0] ST_JUMP     = 4'd9;
  localparam logic [3:0] ST_LOAD_IMM = 4'd10;
  localparam logic [3:0] ST_HALT     = 4'd11;

  localparam logic [5:0] OP_LOAD  = 6'h01;
  localparam logic [5:0] OP_STORE = 6'h02;
  localparam logic [5:0] OP_RTYPE = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_JUMP  = 6'h05;
  localparam logic [5:0] OP_LI    = 6'h06;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  // States that carry a memory request and may wait for mem_ready
  function automatic logic isMemState(input logic [3:0] s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_seq_decode.sv
// mc_seq_decode: combinational control decode of the sequencer state.
// Write enables come out ungated; the top qualifies them with the handshake.
import mc_pkg::*;

module mc_seq_decode #(
  parameter int OP_SIZE = 6,
  parameter int ALU_OP_W = 4,
  parameter logic [ALU_OP_W-1:0] ALU_OP_ADD = 4'd0
) (
  input  logic [3:0]          state,
  input  logic [OP_SIZE-1:0]  opcode,
  input  logic [ALU_OP_W-1:0] alu_op_rtype,
  output logic                mem_req,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_addr_sel,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic                reg_track_sel,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_src,
  output logic [1:0]          reg_wdata_sel,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                halted
);

  // Branching on opcode happens in the next-state logic; nothing here depends on it
  logic unusedOpcode;
  assign unusedOpcode = ^opcode;

  // Per-state control values; anything not named for a state stays 0
  always_comb begin
    mem_req       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    reg_track_sel = 1'b0;
    alu_src_b     = 2'd0;
    pc_src        = 2'd0;
    reg_wdata_sel = 2'd0;
    alu_op        = '0;
    halted        = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        ir_write = 1'b1;
        pc_write = 1'b1;
        alu_op   = ALU_OP_ADD;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd3;
        alu_op    = ALU_OP_ADD;
      end
      ST_MEM_RD: begin
        mem_req      = 1'b1;
        mem_read     = 1'b1;
        mem_addr_sel = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write     = 1'b1;
        reg_track_sel = 1'b1;
      end
      ST_MEM_WR: begin
        mem_req      = 1'b1;
        mem_write    = 1'b1;
        mem_addr_sel = 1'b1;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd1;
        alu_op    = alu_op_rtype;
      end
      ST_ALU_WB: begin
        reg_write     = 1'b1;
        reg_wdata_sel = 2'd1;
      end
      ST_BRANCH: begin
        pc_write_cond = 1'b1;
        pc_src        = 2'd2;
        alu_src_a     = 1'b1;
        alu_src_b     = 2'd1;
        alu_op        = ALU_OP_W'(ALU_SUB);
      end
      ST_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'd1;
      end
      ST_LOAD_IMM: begin
        reg_write     = 1'b1;
        reg_wdata_sel = 2'd2;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multicycle instruction sequencer with retired-instruction counter.
// Build option MC_SEQ_MEM_WAIT_EN: when defined, FETCH/MEM_RD/MEM_WR wait for
// mem_ready; when undefined, mem_ready is ignored and each lasts one cycle.
//
// state    | meaning
// FETCH    | read instruction, latch IR, PC += 4
// DECODE   | branch on opcode
// MEM_ADDR | base + offset address calculation
// MEM_RD   | data read
// MEM_WB   | write MDR to register file
// MEM_WR   | data write
// EXEC     | R-type ALU operation
// ALU_WB   | write ALU result to register file
// BRANCH   | compare, conditional PC update
// JUMP     | unconditional PC update
// LOAD_IMM | write immediate to register file
// HALT     | stopped until reset
import mc_pkg::*;

module mc_sequencer #(
  parameter int OP_SIZE = 6,
  parameter int ALU_OP_W = 4,
  parameter int CNT_WIDTH = 16,
  parameter logic [ALU_OP_W-1:0] ALU_OP_ADD = 4'd0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OP_SIZE-1:0]   opcode,
  input  logic [ALU_OP_W-1:0]  alu_op_rtype,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 mem_addr_sel,
  output logic                 alu_src_a,
  output logic                 reg_track_sel,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           pc_src,
  output logic [1:0]           reg_wdata_sel,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic [3:0]           state,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] instr_count
);

  logic [3:0] nextState;
  logic       memDone;
  logic       stalled;
  logic       decPcWrite;
  logic       decPcWriteCond;
  logic       decIrWrite;
  logic       decRegWrite;
  logic       decMemWrite;

`ifdef MC_SEQ_MEM_WAIT_EN
  assign memDone = mem_ready;
`else
  logic unusedMemReady;
  assign unusedMemReady = mem_ready;
  assign memDone = 1'b1;
`endif

  assign stalled = isMemState(state) & ~memDone;

  // Register-file and PC/IR writes are held off while a memory access waits and while in reset.
  // mem_write stays asserted during a wait so the memory sees a stable request.
  assign pc_write      = decPcWrite & ~stalled & rst_n;
  assign ir_write      = decIrWrite & ~stalled & rst_n;
  assign pc_write_cond = decPcWriteCond & rst_n;
  assign reg_write     = decRegWrite & rst_n;
  assign mem_write     = decMemWrite & rst_n;

  mc_seq_decode #(
    .OP_SIZE    (OP_SIZE),
    .ALU_OP_W   (ALU_OP_W),
    .ALU_OP_ADD (ALU_OP_ADD)
  ) uDecode (
    .state         (state),
    .opcode        (opcode),
    .alu_op_rtype  (alu_op_rtype),
    .mem_req       (mem_req),
    .mem_read      (mem_read),
    .mem_write     (decMemWrite),
    .mem_addr_sel  (mem_addr_sel),
    .ir_write      (decIrWrite),
    .pc_write      (decPcWrite),
    .pc_write_cond (decPcWriteCond),
    .reg_write     (decRegWrite),
    .alu_src_a     (alu_src_a),
    .reg_track_sel (reg_track_sel),
    .alu_src_b     (alu_src_b),
    .pc_src        (pc_src),
    .reg_wdata_sel (reg_wdata_sel),
    .alu_op        (alu_op),
    .halted        (halted)
  );

  // Next-state selection from current state, opcode and memory handshake
  always_comb begin
    nextState = state;
    case (state)
      ST_FETCH: if (memDone) nextState = ST_DECODE;
      ST_DECODE: begin
        if (opcode == OP_SIZE'(OP_LOAD) || opcode == OP_SIZE'(OP_STORE)) nextState = ST_MEM_ADDR;
        else if (opcode == OP_SIZE'(OP_RTYPE)) nextState = ST_EXEC;
        else if (opcode == OP_SIZE'(OP_BEQ))   nextState = ST_BRANCH;
        else if (opcode == OP_SIZE'(OP_JUMP))  nextState = ST_JUMP;
        else if (opcode == OP_SIZE'(OP_LI))    nextState = ST_LOAD_IMM;
        else if (opcode == OP_SIZE'(OP_HALT))  nextState = ST_HALT;
        else                                   nextState = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        if (opcode == OP_SIZE'(OP_LOAD))       nextState = ST_MEM_RD;
        else if (opcode == OP_SIZE'(OP_STORE)) nextState = ST_MEM_WR;
        else                                   nextState = ST_FETCH;
      end
      ST_MEM_RD:   if (memDone) nextState = ST_MEM_WB;
      ST_MEM_WR:   if (memDone) nextState = ST_FETCH;
      ST_MEM_WB:   nextState = ST_FETCH;
      ST_EXEC:     nextState = ST_ALU_WB;
      ST_ALU_WB:   nextState = ST_FETCH;
      ST_BRANCH:   nextState = ST_FETCH;
      ST_JUMP:     nextState = ST_FETCH;
      ST_LOAD_IMM: nextState = ST_FETCH;
      ST_HALT:     nextState = ST_HALT;
      default:     nextState = ST_FETCH;
    endcase
  end

  // State register and retired-instruction counter (bumps on each return to FETCH)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_FETCH;
      instr_count <= '0;
    end else begin
      state <= nextState;
      if (nextState == ST_FETCH && state != ST_FETCH)
        instr_count <= instr_count + CNT_WIDTH'(1);
    end
  end

endmodule
